// File: rtl/ram_sp_be_clr_pkg.sv
// Shared types and helpers for the byte-enable single-port RAM with clear sequencer.
package ram_sp_be_clr_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return register chain: STAGES deep, data only advances with its valid bit,
// so the output word holds between reads.
module ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_vld,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic [DATA_W-1:0] data_p [STAGES];
    logic [STAGES-1:0] vld_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int s = 0; s < STAGES; s++) data_p[s] <= '0;
        end else begin
            vld_p[0] <= load_vld;
            if (load_vld) data_p[0] <= load_data;
            for (int s = 1; s < STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
                if (vld_p[s-1]) data_p[s] <= data_p[s-1];
            end
        end
    end

    assign rdata  = data_p[STAGES-1];
    assign rvalid = vld_p[STAGES-1];

endmodule

// File: rtl/ram_sp_be_clr.sv
// Parametrised single-port RAM: per-byte write enables, 1/2-cycle registered read,
// and a clear sequencer that fills the array with CLR_VAL after reset or on request.
module ram_sp_be_clr
    import ram_sp_be_clr_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 7,
    parameter int                RD_LAT  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cs,
    input  logic                  i_wr_e,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_rvalid,
    input  logic                  i_clr,
    output logic                  o_busy,
    output logic                  o_clr_done
);

    localparam int                DEPTH     = depth_of(ADDR_W);
    localparam int                BE_W      = be_width(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("ram_sp_be_clr: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("ram_sp_be_clr: DATA_W must be a non-zero multiple of 8");
    end

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_done;
    logic              acc, wr_acc, rd_acc;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= ST_IDLE;
                        clr_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_clr) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // A clear request in IDLE takes priority over any access offered that cycle.
    assign acc    = (state == ST_IDLE) && !i_clr && i_cs;
    assign wr_acc = acc && i_wr_e;
    assign rd_acc = acc && !i_wr_e;

    // The array itself is never reset; reset only blocks writes while asserted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (!i_rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= CLR_VAL;
            end else if (wr_acc) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (i_be[k]) mem[i_address][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign rd_data = mem[i_address];

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_rd_pipe (
        .clk       (i_clk),
        .rst       (i_rst),
        .load_vld  (rd_acc),
        .load_data (rd_data),
        .rdata     (o_rdata),
        .rvalid    (o_rvalid)
    );

    assign o_busy     = (state == ST_CLEAR);
    assign o_clr_done = clr_done;

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Bench for ram_sp_be_clr: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// compared every cycle against a behavioural memory model.
module tb_ram_sp_be_clr;

    localparam logic [15:0] CLR = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst, clr, cs, wr;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata1, rdata2;
    logic        rvalid1, rvalid2, busy1, busy2, done1, done2;

    always #5 clk = ~clk;

    ram_sp_be_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .CLR_VAL(CLR)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_wr_e(wr), .i_be(be), .i_address(addr),
        .i_wdata(wdata), .o_rdata(rdata1), .o_rvalid(rvalid1), .i_clr(clr),
        .o_busy(busy1), .o_clr_done(done1));

    ram_sp_be_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .CLR_VAL(CLR)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_wr_e(wr), .i_be(be), .i_address(addr),
        .i_wdata(wdata), .o_rdata(rdata2), .o_rvalid(rvalid2), .i_clr(clr),
        .o_busy(busy2), .o_clr_done(done2));

    int vectors = 0;
    int miscompares = 0;

    // Model: plain memory array, cycles of clearing left, and read-return history
    logic [15:0] m_mem [16];
    int          busy_left;
    logic        done_e;
    logic        hv [2];
    logic [15:0] hd [2];
    logic [15:0] held [2];

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  be;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        ev;
        logic [15:0] ed;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        busy_left = 16;
        done_e    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hv[i] = 1'b0; hd[i] = '0; held[i] = '0;
        end
    endfunction

    function automatic void mdl_edge();
        logic        nv;
        logic [15:0] nd;
        nv = 1'b0;
        nd = '0;
        if (rst) begin
            mdl_reset();
            return;
        end
        done_e = 1'b0;
        if (busy_left > 0) begin
            m_mem[16 - busy_left] = CLR;
            busy_left--;
            done_e = (busy_left == 0);
        end else if (clr) begin
            busy_left = 16;
        end else if (cs && wr) begin
            for (int k = 0; k < 2; k++)
                if (be[k]) m_mem[addr][8*k +: 8] = wdata[8*k +: 8];
        end else if (cs) begin
            nv = 1'b1;
            nd = m_mem[addr];
        end
        hv[1] = hv[0]; hd[1] = hd[0];
        hv[0] = nv;    hd[0] = nd;
        for (int i = 0; i < 2; i++) if (hv[i]) held[i] = hd[i];
    endfunction

    task automatic check_all();
        chk("busy1", busy1, busy_left != 0);
        chk("busy2", busy2, busy_left != 0);
        chk("done1", done1, done_e);
        chk("done2", done2, done_e);
        chk("rvalid1", rvalid1, hv[0]);
        chk("rdata1", rdata1, held[0]);
        chk("rvalid2", rvalid2, hv[1]);
        chk("rdata2", rdata2, held[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
        check_all();
    endtask

    // Runs until o_busy falls (bounded); optionally re-pulses clr or drives ignored accesses.
    task automatic clear_len(input int pulse_at, input bit noise, output int n, output int nd);
        n = 0;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            clr = (k == pulse_at);
            if (noise) begin
                cs = 1'b1; wr = k[0]; addr = 4'd5; be = 2'b11; wdata = 16'h1111;
            end
            tick();
            if (done1) nd++;
            n = k;
            if (!busy1) break;
        end
        clr = 1'b0;
        cs  = 1'b0;
    endtask

    initial begin
        int n, nd, f1, f2, n1, n2;

        tbl[0]  = '{1'b1, 1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 16'hA5A5};
        tbl[1]  = '{1'b1, 1'b1, 2'b01, 4'd3, 16'hFFFF, 1'b0, 16'hA5A5};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, 4'd3, 16'h0000, 1'b1, 16'h12FF};
        tbl[3]  = '{1'b1, 1'b1, 2'b10, 4'd4, 16'hBEEF, 1'b0, 16'h12FF};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 4'd4, 16'h0000, 1'b1, 16'hBEA5};
        tbl[5]  = '{1'b1, 1'b1, 2'b00, 4'd4, 16'h0000, 1'b0, 16'hBEA5};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 4'd4, 16'h0000, 1'b1, 16'hBEA5};
        tbl[7]  = '{1'b1, 1'b0, 2'b11, 4'd3, 16'h9999, 1'b1, 16'h12FF};
        tbl[8]  = '{1'b0, 1'b1, 2'b11, 4'd3, 16'h7777, 1'b0, 16'h12FF};
        tbl[9]  = '{1'b1, 1'b1, 2'b11, 4'd9, 16'hCAFE, 1'b0, 16'h12FF};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 4'd9, 16'h0000, 1'b1, 16'hCAFE};

        rst = 1'b1; clr = 1'b0; cs = 1'b0; wr = 1'b0; be = '0; addr = '0; wdata = '0;
        mdl_reset();
        tick();
        tick();

        // Clear after reset release, then every word reads CLR_VAL
        rst = 1'b0;
        clear_len(-1, 1'b0, n, nd);
        chk("rst_clear_len", n, 16);
        chk("rst_clear_done_cnt", nd, 1);
        for (int i = 0; i < 16; i++) begin
            cs = 1'b1; wr = 1'b0; addr = 4'(i); be = 2'($urandom);
            tick();
            chk("readall_v", rvalid1, 1);
            chk("readall_d", rdata1, CLR);
        end
        cs = 1'b0;
        tick();
        tick();

        // Byte-enable table
        for (int i = 0; i < 11; i++) begin
            cs = tbl[i].cs; wr = tbl[i].wr; be = tbl[i].be;
            addr = tbl[i].addr; wdata = tbl[i].wdata;
            tick();
            chk("tbl_rvalid", rvalid1, tbl[i].ev);
            chk("tbl_rdata", rdata1, tbl[i].ed);
        end
        cs = 1'b0;
        tick();
        tick();

        // Back-to-back reads, latency and contiguity
        for (int i = 0; i < 16; i++) begin
            cs = 1'b1; wr = 1'b1; be = 2'b11; addr = 4'(i); wdata = 16'($urandom);
            tick();
        end
        f1 = -1; f2 = -1; n1 = 0; n2 = 0;
        for (int k = 0; k < 20; k++) begin
            if (k < 16) begin cs = 1'b1; wr = 1'b0; addr = 4'(k); end
            else cs = 1'b0;
            tick();
            if (rvalid1) begin n1++; if (f1 < 0) f1 = k + 1; end
            if (rvalid2) begin n2++; if (f2 < 0) f2 = k + 1; end
        end
        chk("first_valid_lat1", f1, 1);
        chk("first_valid_lat2", f2, 2);
        chk("valid_count_lat1", n1, 16);
        chk("valid_count_lat2", n2, 16);

        // Read in flight completes across a clear; read in the clr cycle is dropped
        cs = 1'b1; wr = 1'b0; addr = 4'd3;
        tick();
        addr = 4'd4; clr = 1'b1;
        tick();
        clr = 1'b0; cs = 1'b0;
        chk("inflight_v2", rvalid2, 1);
        tick();
        chk("dropped_v2", rvalid2, 0);
        clear_len(-1, 1'b0, n, nd);
        chk("drop_clear_len", n, 15);

        // Clear with simultaneous write, re-pulsed clr mid-clear
        cs = 1'b1; wr = 1'b1; be = 2'b11; addr = 4'd7; wdata = 16'h5555; clr = 1'b1;
        tick();
        cs = 1'b0; wr = 1'b0; clr = 1'b0;
        clear_len(5, 1'b0, n, nd);
        chk("req_clear_len", n, 16);
        chk("req_clear_done_cnt", nd, 1);
        cs = 1'b1; wr = 1'b0; addr = 4'd7;
        tick();
        cs = 1'b0;
        chk("clr_write_dropped", rdata1, CLR);

        // Reset asserted mid-clear at counter 9
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        mdl_reset();
        check_all();
        chk("rst_mid_busy", busy1, 1);
        tick();
        tick();
        rst = 1'b0;
        clear_len(-1, 1'b0, n, nd);
        chk("rst_mid_clear_len", n, 16);

        // Accesses offered while busy are ignored
        clr = 1'b1;
        tick();
        clr = 1'b0;
        clear_len(-1, 1'b1, n, nd);
        chk("busy_clear_len", n, 16);
        cs = 1'b1; wr = 1'b0; addr = 4'd5;
        tick();
        cs = 1'b0;
        chk("busy_write_ignored", rdata1, CLR);

        // Randomised traffic with occasional clear requests
        for (int i = 0; i < 400; i++) begin
            clr   = ($urandom_range(0, 49) == 0);
            cs    = ($urandom_range(0, 3) != 0);
            wr    = 1'($urandom);
            be    = 2'($urandom);
            addr  = 4'($urandom);
            wdata = 16'($urandom);
            tick();
        end
        cs = 1'b0; clr = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
